receive_scan_controller: RTL
============================

# receive_scan_controller

Sequencer that steers the receive beamformer across a fixed set of beam angles and measures the energy received at each one. For each angle it fetches the steering sine from an external synchronous ROM, drives `sin_theta`/`sign_bit` into the beamformer and discards settling samples while the beamformer delay buffers refill. It then integrates the beamformed output magnitude and reports a per-angle energy. At the end of a scan it reports the peak angle. It sits between the top-level sweep/display logic and the receive beamformer.

## Interface
Parameters:
- `NUM_ANGLES`, 16: angles per scan, power of 2, ≥2.
- `SIN_WIDTH`, 17: sine magnitude width; matches the beamformer `SIN_WIDTH`.
- `SETTLE_SAMPLES`, 8: valid samples discarded after each angle change, ≥1.
- `SAMPLES_PER_ANGLE`, 256: valid samples integrated per angle, power of 2.
- `ENERGY_WIDTH`, 15+$clog2(SAMPLES_PER_ANGLE): accumulator width, derived.

Ports:
- `clk_in` in 1: system clock; the only clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `start_in` in 1: one-cycle pulse that begins a scan; ignored while busy.
- `data_valid_in` in 1: ADC sample strobe, shared with the beamformer.
- `beam_sample_in` in 16: beamformer `aggregated_waveform`, offset-binary (midscale 0x8000).
- `sin_addr_out` out $clog2(NUM_ANGLES): ROM address, equal to the current angle index.
- `sin_data_in` in SIN_WIDTH+1: ROM data, {sign, magnitude}; valid one cycle after the address.
- `sin_theta_out` out SIN_WIDTH: to the beamformer `sin_theta`.
- `sign_bit_out` out 1: to the beamformer `sign_bit`.
- `busy_out` out 1: high from the cycle after an accepted start until `done_out`, inclusive.
- `angle_valid_out` out 1: one-cycle pulse when `angle_index_out`/`angle_energy_out` are valid.
- `angle_index_out` out $clog2(NUM_ANGLES): angle index being reported.
- `angle_energy_out` out ENERGY_WIDTH: integrated energy for that angle.
- `done_out` out 1: one-cycle pulse when the scan completes.
- `peak_angle_out` out $clog2(NUM_ANGLES): index of the maximum-energy angle from the last completed scan.
- `peak_energy_out` out ENERGY_WIDTH: energy at that angle.

## Operation
- FSM states: IDLE, LOAD, WAIT_ROM, SETTLE, INTEGRATE, REPORT, DONE.
- IDLE:
  - `start_in` → LOAD, with angle index 0.
- LOAD:
  - `sin_addr_out` = index.
  - One cycle, then → WAIT_ROM.
- WAIT_ROM:
  - Registers `sin_data_in[SIN_WIDTH]` into `sign_bit_out` and `sin_data_in[SIN_WIDTH-1:0]` into `sin_theta_out`.
  - Clears the sample counter and the accumulator.
  - One cycle, then → SETTLE.
- SETTLE:
  - Counts `data_valid_in` strobes and discards the samples.
  - After SETTLE_SAMPLES strobes → INTEGRATE.
- INTEGRATE:
  - On each strobe, accumulates |beam_sample_in − 32768|: a 16-bit signed difference whose magnitude is at most 32768.
  - After SAMPLES_PER_ANGLE strobes → REPORT.
  - The accumulator must never wrap.
- REPORT, one cycle:
  - Pulses `angle_valid_out` with the index and energy.
  - Peak update:
    - Index 0 loads the peak candidate unconditionally.
    - Later angles replace the candidate only on strictly greater energy, so ties keep the lower index.
  - Last index → DONE; otherwise increment the index and → LOAD.
- DONE, one cycle:
  - Copies the peak candidate to `peak_angle_out`/`peak_energy_out`.
  - Pulses `done_out`.
  - → IDLE.
- `data_valid_in` in IDLE, LOAD, WAIT_ROM, REPORT or DONE is ignored and not counted.
- `sin_theta_out`/`sign_bit_out` hold from WAIT_ROM until the next WAIT_ROM; they are not cleared at scan end.
- `peak_*` change only in DONE; mid-scan they hold the previous scan's result.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Angle index, counters, accumulator and peak candidate are 0.
- Reset asserted mid-scan:
  - Next cycle all of the above hold, with no `angle_valid_out` or `done_out` pulse.
  - `start_in` is honoured starting with the first cycle `rst_in` is low.
- Timing from `start_in` high at cycle t:
  - LOAD at t+1; `busy_out` high from t+1.
  - WAIT_ROM at t+2.
  - New `sin_theta_out` visible from t+3.
- Angle k's REPORT occurs the cycle after its (SETTLE_SAMPLES+SAMPLES_PER_ANGLE)-th counted strobe.
- DONE follows the last REPORT by one cycle.
- `busy_out` falls the cycle after DONE.
- Outputs `angle_*` and `peak_*` are registered and valid only as described above.
- `start_in` while busy, including in DONE, is ignored.

## Test plan
- Reset: assert `rst_in` 2 cycles, then release → every output is 0 and `busy_out` stays 0 without `start_in`.
- Scan shape: NUM_ANGLES=4, SETTLE=2, SAMPLES=4, `data_valid_in` every 4th cycle, `beam_sample_in`=0x8000 → four `angle_valid_out` pulses with indices 0..3 and energy 0, then `done_out`, `peak_angle_out`=0 and `peak_energy_out`=0.
- Peak detection: `beam_sample_in`=0x8064 only while angle 2 integrates, 0x8000 otherwise → angle-2 energy 400, `peak_angle_out`=2 and `peak_energy_out`=400.
- Magnitude and settle discard: per angle, first 2 strobes carry 0xFFFF, then 0x7FCE → every energy is 200 and the settle samples are excluded.
- Steering: ROM returns {1, 0x0ABCD} at address 1 → `sign_bit_out`=1 and `sin_theta_out`=0x0ABCD from the third cycle after LOAD of angle 1, held through its REPORT.
- Control: `start_in` mid-scan is ignored (a single `done_out`); `rst_in` during INTEGRATE of angle 1 → `busy_out` 0 the next cycle, no `done_out`, and `peak_*` are 0.

Source files
------------

// File: rtl/receive_scan_controller.sv
// Receive beam scan sequencer: steps the beamformer through NUM_ANGLES steering angles,
// integrates beamformed magnitude per angle and reports per-angle energy and the scan peak.
module receive_scan_controller #(
  parameter int NUM_ANGLES        = 16,
  parameter int SIN_WIDTH         = 17,
  parameter int SETTLE_SAMPLES    = 8,
  parameter int SAMPLES_PER_ANGLE = 256,
  parameter int ENERGY_WIDTH      = 15 + $clog2(SAMPLES_PER_ANGLE)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          data_valid_in,
  input  logic [15:0]                   beam_sample_in,
  output logic [$clog2(NUM_ANGLES)-1:0] sin_addr_out,
  input  logic [SIN_WIDTH:0]            sin_data_in,
  output logic [SIN_WIDTH-1:0]          sin_theta_out,
  output logic                          sign_bit_out,
  output logic                          busy_out,
  output logic                          angle_valid_out,
  output logic [$clog2(NUM_ANGLES)-1:0] angle_index_out,
  output logic [ENERGY_WIDTH-1:0]       angle_energy_out,
  output logic                          done_out,
  output logic [$clog2(NUM_ANGLES)-1:0] peak_angle_out,
  output logic [ENERGY_WIDTH-1:0]       peak_energy_out
);

  localparam int IDX_W   = $clog2(NUM_ANGLES);
  localparam int CNT_MAX = (SETTLE_SAMPLES > SAMPLES_PER_ANGLE) ? SETTLE_SAMPLES : SAMPLES_PER_ANGLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MAG_W   = 17;
  localparam int SUM_W   = ((ENERGY_WIDTH > MAG_W) ? ENERGY_WIDTH : MAG_W) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] INTEG_LAST  = CNT_W'(SAMPLES_PER_ANGLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_ANGLES - 1);
  localparam logic [SUM_W-1:0] ACC_MAX     = {{(SUM_W - ENERGY_WIDTH){1'b0}}, {ENERGY_WIDTH{1'b1}}};

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_ROM  = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_INTEGRATE = 3'd4;
  localparam logic [2:0] S_REPORT    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]              state;
  logic [IDX_W-1:0]        angle_idx;
  logic [CNT_W-1:0]        sample_cnt;
  logic [ENERGY_WIDTH-1:0] acc;
  logic [IDX_W-1:0]        cand_idx;
  logic [ENERGY_WIDTH-1:0] cand_energy;

  logic [MAG_W-1:0]        sample_mag;
  logic [SUM_W-1:0]        acc_sum;
  logic [ENERGY_WIDTH-1:0] acc_next;
  logic                    take_peak;
  logic [IDX_W-1:0]        next_cand_idx;
  logic [ENERGY_WIDTH-1:0] next_cand_energy;

  assign sin_addr_out = angle_idx;

  // Offset-binary magnitude, then a saturating add: with full-scale input the true sum can
  // reach 2^ENERGY_WIDTH, one past the largest representable energy, so it clamps instead of wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    sample_mag       = '0;
    acc_sum          = '0;
    acc_next         = acc;
    take_peak        = 1'b0;
    next_cand_idx    = cand_idx;
    next_cand_energy = cand_energy;

    if (beam_sample_in[15]) sample_mag = {2'b00, beam_sample_in[14:0]};
    else                    sample_mag = 17'h08000 - {1'b0, beam_sample_in};

    acc_sum  = SUM_W'(acc) + SUM_W'(sample_mag);
    acc_next = (acc_sum > ACC_MAX) ? {ENERGY_WIDTH{1'b1}} : acc_sum[ENERGY_WIDTH-1:0];

    // Strictly-greater replacement keeps the lowest index on ties.
    take_peak = (angle_idx == '0) || (acc > cand_energy);
    if (take_peak) begin
      next_cand_idx    = angle_idx;
      next_cand_energy = acc;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      state            <= S_IDLE;
      angle_idx        <= '0;
      sample_cnt       <= '0;
      acc              <= '0;
      cand_idx         <= '0;
      cand_energy      <= '0;
      sin_theta_out    <= '0;
      sign_bit_out     <= 1'b0;
      busy_out         <= 1'b0;
      angle_valid_out  <= 1'b0;
      angle_index_out  <= '0;
      angle_energy_out <= '0;
      done_out         <= 1'b0;
      peak_angle_out   <= '0;
      peak_energy_out  <= '0;
    end else begin
      angle_valid_out <= 1'b0;
      done_out        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_in) begin
            state     <= S_LOAD;
            angle_idx <= '0;
            busy_out  <= 1'b1;
          end
        end

        S_LOAD: state <= S_WAIT_ROM;

        // ROM data for the address presented in LOAD is valid now.
        S_WAIT_ROM: begin
          sign_bit_out  <= sin_data_in[SIN_WIDTH];
          sin_theta_out <= sin_data_in[SIN_WIDTH-1:0];
          sample_cnt    <= '0;
          acc           <= '0;
          state         <= S_SETTLE;
        end

        S_SETTLE: begin
          if (data_valid_in) begin
            if (sample_cnt == SETTLE_LAST) begin
              sample_cnt <= '0;
              state      <= S_INTEGRATE;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end

        // The report registers load on the final strobe so they are visible during REPORT.
        S_INTEGRATE: begin
          if (data_valid_in) begin
            acc <= acc_next;
            if (sample_cnt == INTEG_LAST) begin
              state            <= S_REPORT;
              angle_valid_out  <= 1'b1;
              angle_index_out  <= angle_idx;
              angle_energy_out <= acc_next;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end

        S_REPORT: begin
          cand_idx    <= next_cand_idx;
          cand_energy <= next_cand_energy;
          if (angle_idx == IDX_LAST) begin
            state           <= S_DONE;
            done_out        <= 1'b1;
            peak_angle_out  <= next_cand_idx;
            peak_energy_out <= next_cand_energy;
          end else begin
            angle_idx <= angle_idx + IDX_W'(1);
            state     <= S_LOAD;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
